// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : DEPTH-entry circular IF/ID instruction queue with stall/flush bubble.
// Optional FETCHQ_PERF_EN adds saturating stall/flush counters.   Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int N     = 64,
    parameter int IW    = 32,
    parameter int DEPTH = 4,
    parameter int OPW   = 11,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_pc,
    input  logic [IW-1:0]   in_instr,
    input  logic            out_enable,
    output logic            out_valid,
    output logic [N-1:0]    out_pc,
    output logic [IW-1:0]   out_instr,
    output logic [OPW-1:0]  out_opcode,
    output logic [CW-1:0]   count
`ifdef FETCHQ_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_full     = CW'(DEPTH);

    logic [N-1:0]  r_mem_pc    [DEPTH];
    logic [IW-1:0] r_mem_instr [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == c_last_ptr) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (r_count != c_full);
    assign out_valid = (r_count != '0) & ~flush;
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_enable & ~flush;

    // Head is read straight from storage; an empty or flushing queue shows a bubble.
    assign out_pc     = out_valid ? r_mem_pc[r_rd_ptr]    : '0;
    assign out_instr  = out_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign out_opcode = out_instr[IW-1:IW-OPW];
    assign count      = r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem_pc[r_wr_ptr]    <= in_pc;
            r_mem_instr[r_wr_ptr] <= in_instr;
        end
    end

`ifdef FETCHQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_enable && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : scoreboard bench for fetch_queue (DEPTH=4 and DEPTH=3 instances).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        reset4 = 1'b0, flush4 = 1'b0, in_valid4 = 1'b0, out_enable4 = 1'b0;
    logic [63:0] in_pc4 = '0;
    logic [31:0] in_instr4 = '0;
    logic        in_ready4, out_valid4;
    logic [63:0] out_pc4;
    logic [31:0] out_instr4;
    logic [10:0] out_opcode4;
    logic [2:0]  count4;
`ifdef FETCHQ_PERF_EN
    logic [31:0] stall_cnt4, flush_cnt4;
`endif

    // DEPTH=3 instance
    logic        reset3 = 1'b0, flush3 = 1'b0, in_valid3 = 1'b0, out_enable3 = 1'b0;
    logic [63:0] in_pc3 = '0;
    logic [31:0] in_instr3 = '0;
    logic        in_ready3, out_valid3;
    logic [63:0] out_pc3;
    logic [31:0] out_instr3;
    logic [10:0] out_opcode3;
    logic [1:0]  count3;
`ifdef FETCHQ_PERF_EN
    logic [31:0] stall_cnt3, flush_cnt3;
`endif

    fetch_queue #(.N(64), .IW(32), .DEPTH(4), .OPW(11)) u_dut4 (
        .clk(clk), .reset(reset4), .flush(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_pc(in_pc4), .in_instr(in_instr4),
        .out_enable(out_enable4), .out_valid(out_valid4), .out_pc(out_pc4),
        .out_instr(out_instr4), .out_opcode(out_opcode4), .count(count4)
`ifdef FETCHQ_PERF_EN
        , .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
`endif
    );

    fetch_queue #(.N(64), .IW(32), .DEPTH(3), .OPW(11)) u_dut3 (
        .clk(clk), .reset(reset3), .flush(flush3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_pc(in_pc3), .in_instr(in_instr3),
        .out_enable(out_enable3), .out_valid(out_valid3), .out_pc(out_pc3),
        .out_instr(out_instr3), .out_opcode(out_opcode3), .count(count3)
`ifdef FETCHQ_PERF_EN
        , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
    );

    int   tests  = 0;
    int   failed = 0;
    ent_t sb[$];
    int   exp_stall = 0;
    int   exp_flush = 0;

    function automatic logic [31:0] mk_instr(input logic [63:0] pc);
        return 32'(pc) * 32'h9E37_79B9 + 32'h8000_0001;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check head/flags against the model, advance the model.
    task automatic cyc(input int which, input bit iv, input logic [63:0] pc, input bit oe,
                       input bit fl, output bit pushed, output bit popped);
        int          depth;
        bit          exp_valid;
        logic        o_valid, o_ready;
        logic [63:0] o_pc;
        logic [31:0] o_instr;
        logic [10:0] o_op;
        int          o_count;
        depth = (which == 3) ? 3 : 4;
        @(negedge clk);
        if (which == 3) begin
            in_valid3 = iv; in_pc3 = pc; in_instr3 = mk_instr(pc); out_enable3 = oe; flush3 = fl;
        end else begin
            in_valid4 = iv; in_pc4 = pc; in_instr4 = mk_instr(pc); out_enable4 = oe; flush4 = fl;
        end
        #1;
        if (which == 3) begin
            o_valid = out_valid3; o_ready = in_ready3; o_pc = out_pc3;
            o_instr = out_instr3; o_op = out_opcode3; o_count = int'(count3);
        end else begin
            o_valid = out_valid4; o_ready = in_ready4; o_pc = out_pc4;
            o_instr = out_instr4; o_op = out_opcode4; o_count = int'(count4);
        end
        exp_valid = (sb.size() != 0) && !fl;
        chk("out_valid", 64'(o_valid), 64'(exp_valid));
        chk("in_ready", 64'(o_ready), 64'(sb.size() != depth));
        chk("count", 64'(o_count), 64'(sb.size()));
        if (exp_valid) begin
            chk("out_pc", o_pc, sb[0].pc);
            chk("out_instr", 64'(o_instr), 64'(sb[0].instr));
            chk("out_opcode", 64'(o_op), 64'(sb[0].instr[31:21]));
        end else begin
            chk("bubble_pc", o_pc, 64'd0);
            chk("bubble_instr", 64'(o_instr), 64'd0);
            chk("bubble_opcode", 64'(o_op), 64'd0);
        end
`ifdef FETCHQ_PERF_EN
        if (which == 4) begin
            chk("stall_cnt", 64'(stall_cnt4), 64'(exp_stall));
            chk("flush_cnt", 64'(flush_cnt4), 64'(exp_flush));
            if (exp_valid && !oe) exp_stall++;
            if (fl) exp_flush++;
        end
`endif
        pushed = iv && (sb.size() != depth) && !fl;
        popped = exp_valid && oe;
        if (fl) begin
            sb.delete();
        end else begin
            if (popped) void'(sb.pop_front());
            if (pushed) sb.push_back('{pc: pc, instr: mk_instr(pc)});
        end
    endtask

    // Two reset cycles with in_valid held high; queue must stay empty throughout.
    task automatic do_reset(input int which);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (which == 3) begin
                reset3 = 1'b0; in_valid3 = 1'b1; in_pc3 = 64'hDEAD; flush3 = 1'b0; out_enable3 = 1'b0;
            end else begin
                reset4 = 1'b0; in_valid4 = 1'b1; in_pc4 = 64'hDEAD; flush4 = 1'b0; out_enable4 = 1'b0;
            end
            @(negedge clk);
            #1;
            if (which == 3) begin
                chk("rst_count", 64'(count3), 64'd0);
                chk("rst_valid", 64'(out_valid3), 64'd0);
                chk("rst_instr", 64'(out_instr3), 64'd0);
                chk("rst_ready", 64'(in_ready3), 64'd1);
            end else begin
                chk("rst_count", 64'(count4), 64'd0);
                chk("rst_valid", 64'(out_valid4), 64'd0);
                chk("rst_instr", 64'(out_instr4), 64'd0);
                chk("rst_ready", 64'(in_ready4), 64'd1);
`ifdef FETCHQ_PERF_EN
                chk("rst_stall_cnt", 64'(stall_cnt4), 64'd0);
                chk("rst_flush_cnt", 64'(flush_cnt4), 64'd0);
`endif
            end
        end
        if (which == 3) begin
            reset3 = 1'b1; in_valid3 = 1'b0;
        end else begin
            reset4 = 1'b1; in_valid4 = 1'b0;
        end
        sb.delete();
        exp_stall = 0;
        exp_flush = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit psh, pop;
        logic [63:0] pc;
        int pushes, pops;

        // reset with in_valid asserted
        do_reset(4);

        // fill under stall; fifth push must be refused
        for (int i = 0; i < 4; i++) cyc(4, 1, 64'(i * 4), 0, 0, psh, pop);
        cyc(4, 1, 64'h10, 0, 0, psh, pop);
        chk("fifth_push_refused", 64'(psh), 64'd0);
        cyc(4, 0, 64'h0, 0, 0, psh, pop);

        // streaming: pop and push every cycle, order preserved
        pc = 64'h10;
        for (int i = 0; i < 8; i++) begin
            cyc(4, 1, pc, 1, 0, psh, pop);
            if (psh) pc += 64'd4;
        end
        chk("steady_count", 64'(sb.size()), 64'd3);

        // flush with 3 held and a push offered
        cyc(4, 1, 64'h200, 0, 1, psh, pop);
        cyc(4, 0, 64'h0, 1, 0, psh, pop);
        cyc(4, 1, 64'h100, 0, 0, psh, pop);
        cyc(4, 0, 64'h0, 1, 0, psh, pop);
        cyc(4, 0, 64'h0, 1, 0, psh, pop);

        // DEPTH=3: 7 pushes interleaved with pops across pointer wrap
        do_reset(3);
        pushes = 0;
        pops   = 0;
        pc     = 64'h1000;
        for (int i = 0; i < 40 && (pushes < 7 || sb.size() != 0); i++) begin
            cyc(3, pushes < 7, pc, (i % 3) != 0, 0, psh, pop);
            if (psh) begin
                pushes++;
                pc += 64'd4;
            end
            if (pop) pops++;
        end
        chk("d3_pushes", 64'(pushes), 64'd7);
        chk("d3_pops", 64'(pops), 64'd7);
        cyc(3, 0, 64'h0, 1, 0, psh, pop);

        // mid-operation reset drops held entries
        cyc(4, 1, 64'h300, 0, 0, psh, pop);
        cyc(4, 1, 64'h304, 0, 0, psh, pop);
        do_reset(4);
        cyc(4, 0, 64'h0, 1, 0, psh, pop);

`ifdef FETCHQ_PERF_EN
        cyc(4, 1, 64'h400, 0, 0, psh, pop);
        for (int i = 0; i < 5; i++) cyc(4, 0, 64'h0, 0, 0, psh, pop);
        for (int i = 0; i < 2; i++) cyc(4, 0, 64'h0, 0, 1, psh, pop);
        cyc(4, 0, 64'h0, 0, 0, psh, pop);
        chk("perf_stall_total", 64'(stall_cnt4), 64'd5);
        chk("perf_flush_total", 64'(flush_cnt4), 64'd2);
        do_reset(4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
